// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multi-cycle control FSM and the CPU datapath.
// master = control unit side, slave = datapath side.
interface multicycle_control_unit_if;
    logic [5:0]  op;
    logic        zero;
    logic [2:0]  state;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic        IRWre;
    logic        InsMemRW;
    logic        RegWre;
    logic [1:0]  RegDst;
    logic        ExtSel;
    logic        ALUSrcB;
    logic [2:0]  ALUOp;
    logic        mRD;
    logic        mWR;
    logic        DBDataSrc;
    logic [15:0] retired;
    logic        halted;

    modport master (
        input  op, zero,
        output state, PCWre, PCSrc, IRWre, InsMemRW, RegWre, RegDst, ExtSel,
               ALUSrcB, ALUOp, mRD, mWR, DBDataSrc, retired, halted
    );

    modport slave (
        output op, zero,
        input  state, PCWre, PCSrc, IRWre, InsMemRW, RegWre, RegDst, ExtSel,
               ALUSrcB, ALUOp, mRD, mWR, DBDataSrc, retired, halted
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle CPU control FSM: sequences IF/ID/EXE/MEM/WB and decodes datapath
// controls from the registered state and the current opcode.
//
// state  | meaning
// -------+-----------------------------------------------
// IF     | fetch: read instruction memory, load IR
// ID     | decode; j / unknown opcodes complete here
// EXE_A  | ALU op (R-type, addi, ori)
// WB_A   | write ALU result to register file
// EXE_B  | beq compare, PC update from zero flag
// EXE_C  | lw/sw address calculation
// MEM    | data memory access; sw completes here
// WB_C   | write loaded data to register file
// HALT   | parked until reset (reported as 001)
module multicycle_control_unit (
    input  logic                             clk,
    input  logic                             rst_n,
    multicycle_control_unit_if.master        bus
);

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_EXE_C = 4'd2,
        S_MEM   = 4'd3,
        S_WB_C  = 4'd4,
        S_EXE_B = 4'd5,
        S_EXE_A = 4'd6,
        S_WB_A  = 4'd7,
        S_HALT  = 4'd8
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    state_t      state_q;
    logic [15:0] retired_cnt;
    logic        is_r, is_i, is_lw, is_sw, is_beq, is_j, is_halt;
    logic [2:0]  alu_code;
    logic        pcwre;

    always_comb begin
        is_r     = 1'b0;
        is_i     = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_beq   = 1'b0;
        is_j     = 1'b0;
        is_halt  = 1'b0;
        alu_code = 3'b000;
        case (bus.op)
            OP_ADD:  begin is_r = 1'b1; alu_code = 3'b000; end
            OP_SUB:  begin is_r = 1'b1; alu_code = 3'b001; end
            OP_ADDI: begin is_i = 1'b1; alu_code = 3'b000; end
            OP_OR:   begin is_r = 1'b1; alu_code = 3'b011; end
            OP_AND:  begin is_r = 1'b1; alu_code = 3'b100; end
            OP_ORI:  begin is_i = 1'b1; alu_code = 3'b011; end
            OP_SLL:  begin is_r = 1'b1; alu_code = 3'b010; end
            OP_SLT:  begin is_r = 1'b1; alu_code = 3'b101; end
            OP_SW:   begin is_sw = 1'b1; alu_code = 3'b000; end
            OP_LW:   begin is_lw = 1'b1; alu_code = 3'b000; end
            OP_BEQ:  begin is_beq = 1'b1; alu_code = 3'b001; end
            OP_J:    is_j = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IF;
        end else begin
            case (state_q)
                S_IF:    state_q <= S_ID;
                S_ID: begin
                    if (is_halt)              state_q <= S_HALT;
                    else if (is_beq)          state_q <= S_EXE_B;
                    else if (is_lw || is_sw)  state_q <= S_EXE_C;
                    else if (is_r || is_i)    state_q <= S_EXE_A;
                    else                      state_q <= S_IF;
                end
                S_EXE_A: state_q <= S_WB_A;
                S_WB_A:  state_q <= S_IF;
                S_EXE_B: state_q <= S_IF;
                S_EXE_C: state_q <= S_MEM;
                S_MEM:   state_q <= is_lw ? S_WB_C : S_IF;
                S_WB_C:  state_q <= S_IF;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_IF;
            endcase
        end
    end

    // Always reloaded so the counter follows its own value every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retired_cnt <= 16'h0000;
        else        retired_cnt <= retired_cnt + {15'd0, pcwre};
    end

    always_comb begin
        pcwre         = 1'b0;
        bus.PCSrc     = 2'b00;
        bus.IRWre     = 1'b0;
        bus.InsMemRW  = 1'b0;
        bus.RegWre    = 1'b0;
        bus.RegDst    = 2'b00;
        bus.ExtSel    = 1'b0;
        bus.ALUSrcB   = 1'b0;
        bus.ALUOp     = 3'b000;
        bus.mRD       = 1'b0;
        bus.mWR       = 1'b0;
        bus.DBDataSrc = 1'b0;
        bus.halted    = 1'b0;

        if (state_q != S_IF && state_q != S_HALT) begin
            bus.ALUSrcB = is_i || is_lw || is_sw;
            bus.ExtSel  = (bus.op == OP_ADDI) || is_lw || is_sw || is_beq;
            bus.ALUOp   = alu_code;
        end

        case (state_q)
            S_IF: begin
                bus.InsMemRW = 1'b1;
                bus.IRWre    = 1'b1;
            end
            S_ID: begin
                if (is_j) begin
                    pcwre     = 1'b1;
                    bus.PCSrc = 2'b10;
                end else if (!(is_halt || is_beq || is_lw || is_sw || is_r || is_i)) begin
                    pcwre = 1'b1;
                end
            end
            S_EXE_B: begin
                pcwre     = 1'b1;
                bus.PCSrc = bus.zero ? 2'b01 : 2'b00;
            end
            S_MEM: begin
                bus.mRD = is_lw;
                bus.mWR = is_sw;
                pcwre   = is_sw;
            end
            S_WB_A: begin
                pcwre      = 1'b1;
                bus.RegWre = 1'b1;
                bus.RegDst = is_r ? 2'b10 : 2'b01;
            end
            S_WB_C: begin
                pcwre         = 1'b1;
                bus.RegWre    = 1'b1;
                bus.RegDst    = 2'b01;
                bus.DBDataSrc = 1'b1;
            end
            S_HALT:  bus.halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.PCWre   = pcwre;
    assign bus.retired = retired_cnt;
    assign bus.state   = (state_q == S_HALT) ? 3'b001 : state_q[2:0];

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: stimulus queues per-cycle
// expected control vectors, a negedge monitor pops and compares them.
module tb_multicycle_control_unit;

    logic clk;
    logic rst_n;

    multicycle_control_unit_if bus ();

    multicycle_control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [35:0] v;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] ret = 16'h0000;

    function automatic logic [35:0] act();
        return {bus.state, bus.PCWre, bus.PCSrc, bus.IRWre, bus.InsMemRW,
                bus.RegWre, bus.RegDst, bus.ExtSel, bus.ALUSrcB, bus.ALUOp,
                bus.mRD, bus.mWR, bus.DBDataSrc, bus.halted, bus.retired};
    endfunction

    function automatic logic [35:0] vec(logic [2:0] st, logic pcwre, logic [1:0] pcsrc,
                                        logic irw, logic regwre, logic [1:0] regdst,
                                        logic ext, logic srcb, logic [2:0] aluop,
                                        logic mrd, logic mwr, logic db, logic hlt,
                                        logic [15:0] r);
        return {st, pcwre, pcsrc, irw, irw, regwre, regdst, ext, srcb, aluop,
                mrd, mwr, db, hlt, r};
    endfunction

    task automatic check(string tag, logic [35:0] a, logic [35:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h (state|PCWre|PCSrc|IRWre|InsMemRW|RegWre|RegDst|ExtSel|ALUSrcB|ALUOp|mRD|mWR|DBDataSrc|halted|retired)",
                     tag, a, e);
        end
    endtask

    task automatic row(string tag, logic [2:0] st, logic pcwre, logic [1:0] pcsrc,
                       logic irw, logic regwre, logic [1:0] regdst, logic ext,
                       logic srcb, logic [2:0] aluop, logic mrd, logic mwr,
                       logic db, logic hlt);
        exp_t e;
        e.tag = tag;
        e.v   = vec(st, pcwre, pcsrc, irw, regwre, regdst, ext, srcb, aluop,
                    mrd, mwr, db, hlt, ret);
        q.push_back(e);
        if (pcwre) ret = ret + 16'd1;
    endtask

    task automatic fetch_row(string tag);
        row({tag, ":IF"}, 3'd0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0,
            1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.tag, act(), e.v);
        end
    end

    task automatic run_alu(string tag, logic [5:0] op, logic ext, logic srcb,
                           logic [2:0] aluop, logic [1:0] regdst);
        bus.op = op;
        fetch_row(tag);
        row({tag, ":ID"},    3'd1, 0, 2'b00, 0, 0, 2'b00,  ext, srcb, aluop, 0, 0, 0, 0);
        row({tag, ":EXE_A"}, 3'd6, 0, 2'b00, 0, 0, 2'b00,  ext, srcb, aluop, 0, 0, 0, 0);
        row({tag, ":WB_A"},  3'd7, 1, 2'b00, 0, 1, regdst, ext, srcb, aluop, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic run_lw();
        bus.op = 6'b110001;
        fetch_row("lw");
        row("lw:ID",    3'd1, 0, 2'b00, 0, 0, 2'b00, 1, 1, 3'b000, 0, 0, 0, 0);
        row("lw:EXE_C", 3'd2, 0, 2'b00, 0, 0, 2'b00, 1, 1, 3'b000, 0, 0, 0, 0);
        row("lw:MEM",   3'd3, 0, 2'b00, 0, 0, 2'b00, 1, 1, 3'b000, 1, 0, 0, 0);
        row("lw:WB_C",  3'd4, 1, 2'b00, 0, 1, 2'b01, 1, 1, 3'b000, 0, 0, 1, 0);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic sw_front(string tag);
        bus.op = 6'b110000;
        fetch_row(tag);
        row({tag, ":ID"},    3'd1, 0, 2'b00, 0, 0, 2'b00, 1, 1, 3'b000, 0, 0, 0, 0);
        row({tag, ":EXE_C"}, 3'd2, 0, 2'b00, 0, 0, 2'b00, 1, 1, 3'b000, 0, 0, 0, 0);
        row({tag, ":MEM"},   3'd3, 1, 2'b00, 0, 0, 2'b00, 1, 1, 3'b000, 0, 1, 0, 0);
    endtask

    task automatic run_beq(string tag, logic z, logic [1:0] pcsrc);
        bus.op   = 6'b110100;
        bus.zero = z;
        fetch_row(tag);
        row({tag, ":ID"},    3'd1, 0, 2'b00, 0, 0, 2'b00, 1, 0, 3'b001, 0, 0, 0, 0);
        row({tag, ":EXE_B"}, 3'd5, 1, pcsrc, 0, 0, 2'b00, 1, 0, 3'b001, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        bus.zero = 1'b0;
    endtask

    task automatic run_short(string tag, logic [5:0] op, logic [1:0] pcsrc);
        bus.op = op;
        fetch_row(tag);
        row({tag, ":ID"}, 3'd1, 1, pcsrc, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.op   = 6'b000000;
        bus.zero = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            fetch_row("reset");
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;

        run_alu("add",  6'b000000, 0, 0, 3'b000, 2'b10);
        run_alu("sub",  6'b000001, 0, 0, 3'b001, 2'b10);
        run_alu("addi", 6'b000010, 1, 1, 3'b000, 2'b01);
        run_alu("or",   6'b010000, 0, 0, 3'b011, 2'b10);
        run_alu("and",  6'b010001, 0, 0, 3'b100, 2'b10);
        run_alu("ori",  6'b010010, 0, 1, 3'b011, 2'b01);
        run_alu("sll",  6'b011000, 0, 0, 3'b010, 2'b10);
        run_alu("slt",  6'b100110, 0, 0, 3'b101, 2'b10);
        run_lw();
        sw_front("sw");
        repeat (4) @(posedge clk);
        #1;
        run_beq("beq_taken", 1'b1, 2'b01);
        run_beq("beq_not",   1'b0, 2'b00);
        run_short("j",   6'b111000, 2'b10);
        run_short("nop", 6'b000111, 2'b00);

        // Preload the counter near its top so the wrap is reached in a few instructions.
        bus.op = 6'b111000;
        force dut.retired_cnt = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.retired_cnt;
        ret = 16'hFFFE;
        row("wrap_j0:ID", 3'd1, 1, 2'b10, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        run_short("wrap_j1", 6'b111000, 2'b10);
        run_short("wrap_j2", 6'b111000, 2'b10);
        run_short("wrap_j3", 6'b111000, 2'b10);

        sw_front("sw_abort");
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        ret = 16'h0000;
        check("sw_abort:async", act(),
              vec(3'd0, 0, 2'b00, 1, 0, 2'b00, 0, 0, 3'd0, 0, 0, 0, 0, 16'h0000));
        @(posedge clk);
        #1;
        fetch_row("sw_abort_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_short("after_abort", 6'b000111, 2'b00);

        bus.op = 6'b111111;
        fetch_row("halt");
        row("halt:ID", 3'd1, 0, 2'b00, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            row("halt:HALT", 3'd1, 0, 2'b00, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 1);
        repeat (22) @(posedge clk);
        #1;

        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
